// File: rtl/mem_stage_reg_if.sv
// Bus bundle for the memory-stage pipeline register.
// Carries the hazard-unit controls (stall/flush), the incoming EX bundle (M_*),
// the data-memory response (dresp_*) and the registered outgoing bundle (m_*).
//   slave  : view used by mem_stage_reg (consumes M_*, dresp_*, drives m_*)
//   master : view used by whoever feeds the stage (drives M_*, dresp_*)
interface mem_stage_reg_if #(
  parameter int DATA_W = 32,
  parameter int CODE_W = 6,
  parameter int REG_W  = 5
);
  localparam int AW = $clog2(DATA_W / 8);

  logic              stall;
  logic              flush;
  logic              M_valid;
  logic [DATA_W-1:0] M_pc;
  logic [DATA_W-1:0] M_val3;
  logic [CODE_W-1:0] M_icode;
  logic [CODE_W-1:0] M_acode;
  logic [REG_W-1:0]  M_dst;
  logic [2:0]        M_ldop;
  logic [AW-1:0]     M_addr_lo;
  logic              dresp_data_ok;
  logic [DATA_W-1:0] dresp_data;

  logic              m_valid;
  logic [DATA_W-1:0] m_pc;
  logic [DATA_W-1:0] m_val3;
  logic [CODE_W-1:0] m_icode;
  logic [CODE_W-1:0] m_acode;
  logic [REG_W-1:0]  m_dst;
  logic              m_busy;

  modport slave (
    input  stall, flush, M_valid, M_pc, M_val3, M_icode, M_acode, M_dst,
           M_ldop, M_addr_lo, dresp_data_ok, dresp_data,
    output m_valid, m_pc, m_val3, m_icode, m_acode, m_dst, m_busy
  );

  modport master (
    output stall, flush, M_valid, M_pc, M_val3, M_icode, M_acode, M_dst,
           M_ldop, M_addr_lo, dresp_data_ok, dresp_data,
    input  m_valid, m_pc, m_val3, m_icode, m_acode, m_dst, m_busy
  );
endinterface

// File: rtl/mem_stage_reg.sv
// Memory-stage pipeline register (EX->MEM->WB) for the 5-stage core.
// Captures the instruction bundle when the stage advances, waits for the
// data-memory response of loads (raising m_busy meanwhile) and produces the
// load-extended or passthrough writeback value on m_val3.
// Ports:
//   clk   : clock
//   reset : synchronous active-high reset
//   bus   : mem_stage_reg_if.slave (stall/flush, M_* bundle, dresp_*, m_* outputs)
module mem_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CODE_W = 6,
  parameter int REG_W  = 5
) (
  input  logic           clk,
  input  logic           reset,
  mem_stage_reg_if.slave bus
);
  localparam int LANES = DATA_W / 8;
  localparam int AW    = $clog2(LANES);

  typedef enum logic [1:0] {IDLE, WAIT, HAVE, DRAIN} state_t;

  state_t            state_reg, state_next;
  logic              valid_reg;
  logic [DATA_W-1:0] pc_reg;
  logic [DATA_W-1:0] val3_reg;
  logic [CODE_W-1:0] icode_reg;
  logic [CODE_W-1:0] acode_reg;
  logic [REG_W-1:0]  dst_reg;
  logic [2:0]        ldop_reg;
  logic [AW-1:0]     addr_lo_reg;
  logic [DATA_W-1:0] lat_reg;     // load value held while the stage is stalled
  logic              armed_reg;   // a load response may legitimately be in flight

  logic              busy;
  logic              adv;
  logic              new_load;
  logic              resp_ok;
  logic [DATA_W-1:0] ext_val;
  logic [DATA_W-1:0] val3_out;

  function automatic logic is_load(input logic [2:0] op);
    return (op >= 3'd1) && (op <= 3'd5);
  endfunction

  assign resp_ok  = bus.dresp_data_ok;
  assign busy     = (state_reg == DRAIN) || ((state_reg == WAIT) && !resp_ok);
  assign adv      = !bus.stall && !busy;
  // The entry about to be captured needs a memory response.
  assign new_load = bus.M_valid && !bus.flush && is_load(bus.M_ldop);

  // Little-endian lane views of the raw response word.
  logic [7:0]  byte_lane [LANES];
  logic [15:0] half_lane [LANES/2];

  for (genvar gi = 0; gi < LANES; gi++) begin : g_byte
    assign byte_lane[gi] = bus.dresp_data[8*gi +: 8];
  end
  for (genvar gi = 0; gi < LANES/2; gi++) begin : g_half
    assign half_lane[gi] = bus.dresp_data[16*gi +: 16];
  end

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] sel_word;

  assign sel_byte = byte_lane[addr_lo_reg];
  // Halfword select ignores address bit 0.
  assign sel_half = half_lane[addr_lo_reg[AW-1:1]];
  assign sel_word = bus.dresp_data[31:0];

  always_comb begin
    ext_val = '0;
    case (ldop_reg)
      3'd1:    ext_val = DATA_W'($signed(sel_byte));
      3'd2:    ext_val = DATA_W'(sel_byte);
      3'd3:    ext_val = DATA_W'($signed(sel_half));
      3'd4:    ext_val = DATA_W'(sel_half);
      3'd5:    ext_val = DATA_W'($signed(sel_word));
      default: ext_val = '0;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    val3_out   = val3_reg;
    case (state_reg)
      IDLE: begin
        if (adv) state_next = new_load ? WAIT : IDLE;
      end
      WAIT: begin
        if (resp_ok) begin
          val3_out = ext_val;
          if (bus.stall) state_next = bus.flush ? IDLE : HAVE;
          else           state_next = new_load ? WAIT : IDLE;
        end else if (bus.flush) begin
          state_next = DRAIN;
        end
      end
      HAVE: begin
        val3_out = lat_reg;
        if (adv)            state_next = new_load ? WAIT : IDLE;
        else if (bus.flush) state_next = IDLE;
      end
      DRAIN: begin
        // Response belongs to a flushed load; just wait it out.
        if (resp_ok) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      valid_reg   <= 1'b0;
      pc_reg      <= '0;
      val3_reg    <= '0;
      icode_reg   <= '0;
      acode_reg   <= '0;
      dst_reg     <= '0;
      ldop_reg    <= '0;
      addr_lo_reg <= '0;
      lat_reg     <= '0;
      armed_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (adv) begin
        valid_reg   <= bus.M_valid && !bus.flush;
        pc_reg      <= bus.M_pc;
        val3_reg    <= bus.M_val3;
        icode_reg   <= bus.M_icode;
        acode_reg   <= bus.M_acode;
        dst_reg     <= bus.M_dst;
        ldop_reg    <= bus.flush ? 3'd0 : bus.M_ldop;
        addr_lo_reg <= bus.M_addr_lo;
      end else if (bus.flush) begin
        valid_reg <= 1'b0;
        ldop_reg  <= 3'd0;
      end
      if ((state_reg == WAIT) && resp_ok) lat_reg <= ext_val;
      if (adv && new_load) armed_reg <= 1'b1;
    end
  end

  assign bus.m_valid = valid_reg;
  assign bus.m_pc    = pc_reg;
  assign bus.m_val3  = val3_out;
  assign bus.m_icode = icode_reg;
  assign bus.m_acode = acode_reg;
  assign bus.m_dst   = dst_reg;
  assign bus.m_busy  = busy;

  // A response with no load waiting for it is a memory-side protocol error.
  // Before the first load after reset a stale response is tolerated.
  a_no_orphan_resp: assert property (@(posedge clk) disable iff (reset)
    !(armed_reg && resp_ok && ((state_reg == IDLE) || (state_reg == HAVE))));
endmodule

// File: doc/mem_stage_reg.md
Name: mem_stage_reg

Overview:
- Parametrised EX→MEM→WB pipeline register for the memory stage of the mycpu 5-stage core.
- Captures the instruction bundle from the previous stage, with stall, flush and valid-bit support.
- Waits on an asynchronous-latency data-memory response for loads, asserting a busy signal to the hazard unit while it waits.
- Extracts and extends byte/half/word load data into the writeback value. Non-load instructions pass their value through unchanged.

Parameters:
DATA_W, 32, width of pc, value and memory data paths (must be 32 or 64; byte lanes = DATA_W/8)
CODE_W, 6, width of icode/acode fields
REG_W, 5, width of destination register index

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
stall  in  1  hold register contents (from hazard unit)
flush  in  1  replace captured entry with a bubble
M_valid  in  1  incoming bundle is a real instruction
M_pc  in  DATA_W  incoming pc
M_val3  in  DATA_W  incoming ALU result / passthrough value
M_icode  in  CODE_W  incoming instruction code
M_acode  in  CODE_W  incoming ALU code
M_dst  in  REG_W  incoming destination register
M_ldop  in  3  load kind: 0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW (6/7 treated as none)
M_addr_lo  in  log2(DATA_W/8)  low address bits of the load
dresp_data_ok  in  1  data-memory response valid this cycle
dresp_data  in  DATA_W  raw data-memory read word
m_valid  out  1  registered valid
m_pc, m_icode, m_acode, m_dst  out  as inputs  registered bundle
m_val3  out  DATA_W  writeback value (load-extended or passthrough)
m_busy  out  1  stage cannot advance; hazard unit must stall upstream

Behaviour:
- Reset:
  - All registered fields are 0 and state is IDLE.
  - m_valid=0, m_val3=0, m_busy=0.
- Advance condition: adv = ~stall & ~m_busy. Capture happens on the clk edge when adv=1.
- On capture:
  - All bundle fields load from M_*.
  - m_valid <= M_valid & ~flush.
  - If flush is high, m_ldop is cleared to 0.
- Flush has priority over stall. When flush=1 with adv=0, m_valid and m_ldop clear and all other fields hold.
- FSM states: IDLE, WAIT, HAVE, DRAIN.
  - IDLE: no load pending. m_busy=0; m_val3 = registered val3. Capturing a valid load (ldop 1..5) moves to WAIT.
  - WAIT: m_busy = ~dresp_data_ok. When dresp_data_ok=1:
    - m_val3 = extended dresp_data in that same cycle (combinational), and the extended value is latched.
    - If stall=1, next state is HAVE.
    - Otherwise the stage captures, and the next state is WAIT or IDLE according to the new entry.
    - A flush arriving in WAIT while dresp_data_ok=0 moves to DRAIN.
  - HAVE: m_val3 = latched value, m_busy=0. Leaves on the next capture (to WAIT or IDLE per the new entry). A flush returns it to IDLE.
  - DRAIN: m_valid=0, m_busy=1. The outstanding response is discarded. On dresp_data_ok, go to IDLE.
- A response arriving in IDLE or HAVE is ignored. It is a protocol error and must be flagged by an assertion.
- Extraction (little-endian):
  - byte = lane M_addr_lo; half = lane pair selected by the high bits of addr_lo (the bit-0 address is ignored).
  - LB and LH sign-extend to DATA_W; LBU and LHU zero-extend.
  - LW takes the low 32 bits, sign-extended when DATA_W=64.
- Latency:
  - Non-loads: value is visible the cycle after capture.
  - Loads: value is visible in the first cycle dresp_data_ok=1 (minimum 1 cycle after capture).
- Reset mid-WAIT or DRAIN goes straight to IDLE. The in-flight response is not tracked after reset.

Test Plan:
- Passthrough: capture icode=ADD, ldop=0, val3=0x1234_5678, no stall → next cycle m_val3=0x1234_5678, m_valid=1, m_busy=0.
- Load with 3-cycle latency: ldop=LB, addr_lo=2, dresp_data=0x0080_0000 with data_ok 3 cycles after capture →
  - m_busy=1 for 2 cycles.
  - Then m_val3=0xFFFF_FF80 and m_busy=0.
  - With LBU instead, m_val3=0x0000_0080.
- Half extraction: LH addr_lo=2, data 0x8001_7FFF → 0xFFFF_8001; LHU addr_lo=0 → 0x0000_7FFF.
- Stall on data return: data_ok=1 while stall=1 →
  - State is HAVE and m_val3 holds the loaded value across 4 stalled cycles.
  - Upstream changes to M_* are not captured.
- Flush during WAIT: flush before data_ok →
  - m_valid=0 and m_busy=1 until data_ok.
  - The response is discarded, the FSM returns to IDLE, and the next capture proceeds normally.
- Reset mid-WAIT: reset asserted → next cycle all outputs 0, m_busy=0; a stale data_ok arriving afterwards does not change m_val3.
